// File: rtl/irq_pkg.sv
// Shared types and defaults for the interrupt controller slice.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ALERT    = 2'd1,
    WAIT_ACK = 2'd2,
    SERVICE  = 2'd3
  } irq_state_e;

  localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_0100;
  localparam logic [31:0] DEF_VEC_STRIDE = 32'd16;

  // Handler entry point for a source; 32-bit wrap is intended.
  function automatic logic [31:0] calc_vec(input logic [31:0] base,
                                           input logic [31:0] stride,
                                           input logic [31:0] id);
    return base + id * stride;
  endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Bundle of source, enable, fetch-handshake and status signals of the interrupt controller.
// Latency: none (wires only).
// Backpressure: fetch acknowledges with interrupt; the controller re-alerts until it does.
interface irq_ctrl_if #(
  parameter int NUM_SRC = 8
);
  localparam int ID_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0] irq_src;
  logic [NUM_SRC-1:0] irq_enable;
  logic               interrupt;
  logic               irq_done;
  logic               alert;
  logic               interrupt_mask;
  logic [ID_W-1:0]    irq_id;
  logic [31:0]        vector_pc;
  logic [NUM_SRC-1:0] pending;

  // Controller side
  modport master (
    input  irq_src, irq_enable, interrupt, irq_done,
    output alert, interrupt_mask, irq_id, vector_pc, pending
  );

  // Fetch / source side
  modport slave (
    output irq_src, irq_enable, interrupt, irq_done,
    input  alert, interrupt_mask, irq_id, vector_pc, pending
  );

endinterface

// File: rtl/irq_prio_enc.sv
// Picks the lowest-index asserted request and flags whether any request exists.
// Latency: purely combinational.
// Backpressure: none.
module irq_prio_enc #(
  parameter  int NUM_SRC = 8,
  localparam int ID_W    = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               vld,
  output logic [ID_W-1:0]    id
);

  // Scan from the top down so the lowest asserted index is the last one written.
  always_comb begin
    vld = 1'b0;
    id  = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        vld = 1'b1;
        id  = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches sources, alerts fetch for the lowest eligible one, masks until irq_done.
// Latency: eligible pending -> alert 1 cycle; ack -> interrupt_mask 1 cycle. IRQ_EDGE_DETECT_EN selects edge mode.
// Backpressure: no ack within ACK_TIMEOUT cycles re-pulses alert with the same id; new sources only pend.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int          NUM_SRC     = 8,
  parameter logic [31:0] VEC_BASE    = DEF_VEC_BASE,
  parameter logic [31:0] VEC_STRIDE  = DEF_VEC_STRIDE,
  parameter int          ACK_TIMEOUT = 16
) (
  input logic        clk,
  input logic        rst_n,
  irq_ctrl_if.master bus
);

  localparam int ID_W  = $clog2(NUM_SRC);
  localparam int CNT_W = $clog2(ACK_TIMEOUT);

  irq_state_e         state;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_SRC-1:0] pend_q;
  logic [NUM_SRC-1:0] set_vec;
  logic [NUM_SRC-1:0] clr_vec;
  logic               win_vld;
  logic [ID_W-1:0]    win_id;
  logic               ack_take;
  logic               alert_q;
  logic               mask_q;
  logic [ID_W-1:0]    id_q;
  logic [31:0]        vec_q;

  irq_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio (
    .req (pend_q & bus.irq_enable),
    .vld (win_vld),
    .id  (win_id)
  );

  // Fetch's acknowledge only counts while a handshake is in flight.
  assign ack_take = bus.interrupt && (state == ALERT || state == WAIT_ACK);

`ifdef IRQ_EDGE_DETECT_EN
  logic [NUM_SRC-1:0] src_q;

  // Previous source levels for rising-edge detection; a source high out of reset counts as an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) src_q <= '0;
    else        src_q <= bus.irq_src;
  end

  // Rising edges pend a source.
  always_comb begin
    set_vec = bus.irq_src & ~src_q;
  end
`else
  // Level mode: an asserted source pends every cycle it is high.
  always_comb begin
    set_vec = bus.irq_src;
  end
`endif

  // Entering SERVICE retires the winner's pending bit.
  always_comb begin
    clr_vec = '0;
    if (ack_take) clr_vec[id_q] = 1'b1;
  end

  // Pending register; a same-cycle set wins over the service-entry clear.
  always_ff @(posedge clk) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= (pend_q & ~clr_vec) | set_vec;
  end

  // Handshake FSM with registered alert/mask/id/vector outputs and the ack timeout counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      alert_q <= 1'b0;
      mask_q  <= 1'b0;
      id_q    <= '0;
      vec_q   <= VEC_BASE;
    end else begin
      alert_q <= 1'b0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            state   <= ALERT;
            alert_q <= 1'b1;
            id_q    <= win_id;
            vec_q   <= calc_vec(VEC_BASE, VEC_STRIDE, 32'(win_id));
          end
        end
        ALERT: begin
          cnt <= '0;
          if (bus.interrupt) begin
            state  <= SERVICE;
            mask_q <= 1'b1;
          end else begin
            state <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          cnt <= cnt + 1'b1;
          if (bus.interrupt) begin
            state  <= SERVICE;
            mask_q <= 1'b1;
          end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
            state   <= ALERT;
            alert_q <= 1'b1;
          end
        end
        SERVICE: begin
          if (bus.irq_done) begin
            state  <= IDLE;
            mask_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.alert          = alert_q;
  assign bus.interrupt_mask = mask_q;
  assign bus.irq_id         = id_q;
  assign bus.vector_pc      = vec_q;
  assign bus.pending        = pend_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed and randomized checks of irq_ctrl against a cycle-level behavioural model.
// Latency: inputs are driven 1 time unit after each rising edge; outputs sampled 1 unit after the edge.
// Backpressure: the bench plays the fetch stage, acking immediately, late or never.
module tb_irq_ctrl;

  localparam int N = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  irq_ctrl_if #(.NUM_SRC(N)) bus ();

  irq_ctrl #(
    .NUM_SRC     (N),
    .VEC_BASE    (32'h0000_0100),
    .VEC_STRIDE  (32'd16),
    .ACK_TIMEOUT (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: phase 0 = no interrupt taken, 1 = waiting for fetch, 2 = handler running.
  logic [N-1:0] m_pend  = '0;
  logic [N-1:0] m_prev  = '0;
  int           m_phase = 0;
  int           m_age   = 0;   // cycles since the latest alert pulse
  int           m_id    = 0;
  logic         m_alert = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [N-1:0] set;
    logic [N-1:0] clr;
    bit           found;
    clr = '0;
    if (!rst_n) begin
      m_pend  = '0;
      m_prev  = '0;
      m_phase = 0;
      m_age   = 0;
      m_id    = 0;
      m_alert = 1'b0;
    end else begin
`ifdef IRQ_EDGE_DETECT_EN
      set = bus.irq_src & ~m_prev;
`else
      set = bus.irq_src;
`endif
      m_alert = 1'b0;
      if (m_phase == 0) begin
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
          if (!found && m_pend[i] && bus.irq_enable[i]) begin
            found   = 1'b1;
            m_id    = i;
            m_phase = 1;
            m_age   = 0;
            m_alert = 1'b1;
          end
        end
      end else if (m_phase == 1) begin
        if (bus.interrupt) begin
          m_phase   = 2;
          clr[m_id] = 1'b1;
        end else begin
          m_age++;
          if (m_age == 17) begin
            m_age   = 0;
            m_alert = 1'b1;
          end
        end
      end else if (bus.irq_done) begin
        m_phase = 0;
      end
      m_pend = (m_pend & ~clr) | set;
      m_prev = bus.irq_src;
    end
  endtask

  task automatic compare_model();
    check("alert",     32'(bus.alert),          32'(m_alert));
    check("mask",      32'(bus.interrupt_mask), 32'(m_phase == 2));
    check("irq_id",    32'(bus.irq_id),         32'(m_id));
    check("vector_pc", bus.vector_pc,           32'h100 + 32'(m_id) * 32'd16);
    check("pending",   32'(bus.pending),        32'(m_pend));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  initial begin
    bus.irq_src    = '0;
    bus.irq_enable = '1;
    bus.interrupt  = 1'b0;
    bus.irq_done   = 1'b0;
    rst_n          = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_alert",  32'(bus.alert), 32'd0);
    check("rst_mask",   32'(bus.interrupt_mask), 32'd0);
    check("rst_id",     32'(bus.irq_id), 32'd0);
    check("rst_vec",    bus.vector_pc, 32'h100);
    check("rst_pend",   32'(bus.pending), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: single source 3, ack two cycles after the alert
    bus.irq_src = 8'h08; tick();
    check("t1_pend", 32'(bus.pending), 32'h08);
    bus.irq_src = '0; tick();
    check("t1_alert", 32'(bus.alert), 32'd1);
    check("t1_id",    32'(bus.irq_id), 32'd3);
    check("t1_vec",   bus.vector_pc, 32'h130);
    tick(); tick();
    bus.interrupt = 1'b1; tick();
    bus.interrupt = 1'b0;
    check("t1_mask", 32'(bus.interrupt_mask), 32'd1);
    check("t1_pend0", 32'(bus.pending), 32'd0);
    tick(); tick();
    bus.irq_done = 1'b1; tick();
    bus.irq_done = 1'b0;
    check("t1_unmask", 32'(bus.interrupt_mask), 32'd0);
    tick();

    // 2: simultaneous sources 5 and 1, back-to-back service
    bus.irq_src = 8'h22; tick();
    bus.irq_src = '0; tick();
    check("t2_id1",  32'(bus.irq_id), 32'd1);
    check("t2_vec1", bus.vector_pc, 32'h110);
    bus.interrupt = 1'b1; tick();
    bus.interrupt = 1'b0;
    bus.irq_done  = 1'b1; tick();
    bus.irq_done  = 1'b0;
    check("t2_idle_gap", 32'(bus.alert), 32'd0);
    tick();
    check("t2_alert5", 32'(bus.alert), 32'd1);
    check("t2_id5",    32'(bus.irq_id), 32'd5);
    check("t2_vec5",   bus.vector_pc, 32'h150);
    bus.interrupt = 1'b1; tick();
    bus.interrupt = 1'b0;
    bus.irq_done  = 1'b1; tick();
    bus.irq_done  = 1'b0;
    tick();

    // 3: no ack, alert re-pulses every 17 cycles with the same id
    bus.irq_src = 8'h01; tick();
    bus.irq_src = '0; tick();
    check("t3_alert0", 32'(bus.alert), 32'd1);
    for (int k = 1; k <= 34; k++) begin
      tick();
      check("t3_repulse", 32'(bus.alert), 32'(k % 17 == 0));
    end
    check("t3_id", 32'(bus.irq_id), 32'd0);
    bus.interrupt = 1'b1; tick();
    bus.interrupt = 1'b0;
    check("t3_mask", 32'(bus.interrupt_mask), 32'd1);
    bus.irq_done = 1'b1; tick();
    bus.irq_done = 1'b0;
    tick();

    // 4: ack in the alert cycle, then stray handshake inputs in IDLE
    bus.irq_src = 8'h40; tick();
    bus.irq_src = '0; tick();
    bus.interrupt = 1'b1; tick();
    bus.interrupt = 1'b0;
    check("t4_mask", 32'(bus.interrupt_mask), 32'd1);
    bus.irq_done = 1'b1; tick();
    bus.interrupt = 1'b1; tick();
    bus.interrupt = 1'b0;
    bus.irq_done  = 1'b0;
    check("t4_stray_alert", 32'(bus.alert), 32'd0);
    check("t4_stray_mask",  32'(bus.interrupt_mask), 32'd0);
    tick();

    // 5: disabled source pends but does not win until enabled
    bus.irq_enable = 8'hFB;
    bus.irq_src = 8'h04; tick();
    bus.irq_src = '0; tick(); tick();
    check("t5_pend",    32'(bus.pending), 32'h04);
    check("t5_noalert", 32'(bus.alert), 32'd0);
    bus.irq_enable = '1; tick();
    check("t5_alert", 32'(bus.alert), 32'd1);
    check("t5_id",    32'(bus.irq_id), 32'd2);
    bus.interrupt = 1'b1; tick();
    bus.interrupt = 1'b0;
    bus.irq_done  = 1'b1; tick();
    bus.irq_done  = 1'b0;
    tick();

    // 6: reset during SERVICE with another source pending
    bus.irq_src = 8'h10; tick();
    bus.irq_src = '0; tick();
    bus.interrupt = 1'b1; tick();
    bus.interrupt = 1'b0;
    bus.irq_src = 8'h01; tick();
    bus.irq_src = '0;
    rst_n = 1'b0; tick();
    check("t6_mask",  32'(bus.interrupt_mask), 32'd0);
    check("t6_pend",  32'(bus.pending), 32'd0);
    check("t6_id",    32'(bus.irq_id), 32'd0);
    check("t6_vec",   bus.vector_pc, 32'h100);
    check("t6_alert", 32'(bus.alert), 32'd0);
    rst_n = 1'b1; tick();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      bus.irq_src    = ($urandom_range(0, 3) == 0) ? (N'($urandom) & N'($urandom)) : '0;
      bus.irq_enable = ($urandom_range(0, 5) == 0) ? N'($urandom) : '1;
      bus.interrupt  = ($urandom_range(0, 3) == 0);
      bus.irq_done   = ($urandom_range(0, 4) == 0);
      rst_n          = ($urandom_range(0, 399) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
